// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_cond_negate.sv
// Conditional two's-complement negation: result = negate ? -value : value.
module mult_cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed/unsigned shift-and-add multiplier, one partial product per BUSY cycle.
// Define SEQ_MULT_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t                 state;
    logic [2*WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]       mplier;
    logic [2*WIDTH-1:0]     acc;
    logic [CNT_W-1:0]       cnt;
    logic                   sign;

    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [2*WIDTH-1:0]     fixed;
    logic [WIDTH-1:0]       mplier_shift;
    logic                   busy_last;

    // The most negative operand maps to 2^(WIDTH-1), still exact as an unsigned WIDTH-bit value.
    mult_cond_negate #(.W(WIDTH)) u_neg_a (
        .value  (a),
        .negate (op_signed & a[WIDTH-1]),
        .result (mag_a)
    );

    mult_cond_negate #(.W(WIDTH)) u_neg_b (
        .value  (b),
        .negate (op_signed & b[WIDTH-1]),
        .result (mag_b)
    );

    mult_cond_negate #(.W(2*WIDTH)) u_neg_res (
        .value  (acc),
        .negate (sign),
        .result (fixed)
    );

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign mplier_shift = mplier >> 1;

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign busy_last = (mplier_shift == '0);
`else
    assign busy_last = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        sign   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_shift;
                    cnt    <= cnt - CNT_W'(1);
                    if (busy_last) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Negating a zero accumulator yields zero, so no negative-zero case exists.
                    product <= fixed;
                    state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier (WIDTH = 32) against a plain-arithmetic model.
module tb_seq_multiplier;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            op_signed = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  product;

    int n_checks = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_signed (op_signed),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                  input logic sgn);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy;
        if (sgn) begin
            sx = 64'(signed'(x));
            sy = 64'(signed'(y));
            return 64'(sx * sy);
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    function automatic int model_latency(input logic [W-1:0] y, input logic sgn);
        int busy;
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [W-1:0] m;
        m = (sgn && y[W-1]) ? (~y + 1) : y;
        busy = 1;
        for (int i = 0; i < W; i++) if (m[i]) busy = i + 1;
`else
        busy = W;
`endif
        return busy + 1;
    endfunction

    // Issue one operation, check latency and result, hold DONE for 'hold' cycles, then release.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sgn, input int hold, input logic poke);
        logic [63:0] exp;
        int lat;
        int k;
        exp = model_product(x, y, sgn);
        lat = model_latency(y, sgn);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = x; b = y; op_signed = sgn; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_product"}, product, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke) begin
                a = $urandom; b = $urandom; op_signed = $urandom_range(0, 1); in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            check({tag, "_hold_product"}, product, exp);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rel_product"}, product, exp);
        @(negedge clk);
        out_ready = 1'b0;
        // in_valid may still be high from the poke: the release edge must not have accepted it.
        check({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("neg7x6", 32'hFFFF_FFF9, 32'd6, 1'b1, 0, 1'b0);
        run_op("minxmin_s", 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 1'b0);
        run_op("maxxmax_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        run_op("hold5", 32'd12345, 32'hFFFF_FF00, 1'b1, 5, 1'b1);
        run_op("zero_a_s", 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
        run_op("zero_b_s", 32'h8000_0000, 32'd0, 1'b1, 0, 1'b0);
        run_op("b_one", 32'hDEAD_BEEF, 32'd1, 1'b0, 0, 1'b0);
        run_op("b_msb_u", 32'd3, 32'h8000_0000, 1'b0, 0, 1'b0);
        run_op("neg1xneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);

        // Reset in the middle of BUSY discards the operation.
        @(negedge clk);
        a = 32'd1000; b = 32'd777; op_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst", 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b1, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operand pair presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: op_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
REQ-007 SHALL have ports: a, b  input  WIDTH  multiplicand and multiplier.
REQ-008 SHALL have port: out_valid  output  1  product available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes product.
REQ-010 SHALL have port: product  output  2*WIDTH  result, registered.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, FIX, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 SHALL accept on the edge where in_valid && in_ready: latch |a|, |b| (magnitudes if op_signed, raw otherwise), result sign = a[MSB]^b[MSB] if op_signed, else 0; go to BUSY.
REQ-014 SHALL, each BUSY cycle: if multiplier-register LSB = 1, add multiplicand register (2*WIDTH, zero-extended) to accumulator; shift multiplicand left by 1 and multiplier right by 1; decrement iteration counter.
REQ-015 SHALL leave BUSY for FIX after exactly WIDTH BUSY cycles (default build).
REQ-016 SHALL, in FIX, load product with accumulator, two's-complement negated if result sign = 1; go to DONE.
REQ-017 SHALL give latency: accept edge E -> out_valid high after edge E+WIDTH+1.
REQ-018 SHALL hold product and out_valid stable in DONE until out_ready = 1; on that edge return to IDLE (out_valid low, product retains value).
REQ-019 SHALL ignore in_valid outside IDLE; no same-cycle release-and-accept (one idle cycle between operations).
REQ-020 SHALL produce the exact 2*WIDTH-bit result for all inputs, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) (magnitude 2^(WIDTH-1) held unsigned in WIDTH bits).
REQ-021 SHALL produce product 0 (never negative zero) for any zero operand.

Reset
REQ-022 SHALL, on rst low (asynchronous, any state including mid-BUSY), force IDLE, product = 0, out_valid = 0, in_ready = 1, and clear all internal registers; an in-flight operation is discarded.
REQ-023 SHALL be ready to accept on the first rising clk edge after rst deasserts.

Configuration
REQ-024 SHALL support macro SEQ_MULT_EARLY_TERM_EN: when defined, BUSY exits to FIX at the end of the first BUSY cycle whose post-shift multiplier register is zero (minimum 1 BUSY cycle), so BUSY length = bit index of highest set bit of |b| + 1, and 1 for b = 0.
REQ-025 SHALL, when SEQ_MULT_EARLY_TERM_EN is undefined, use fixed WIDTH-cycle BUSY per REQ-015; results are identical in both builds.

Structure
REQ-026 SHALL place the state enum type and iteration-counter width constant ($clog2(WIDTH+1)) in shared package seq_mult_pkg.
REQ-027 SHALL use one sub-module, mult_cond_negate (parameter W; conditional two's-complement negate), instantiated for both operand magnitude and result sign fix.

Verification (WIDTH = 32)
REQ-028 SHALL test: signed a = -7, b = 6 -> product 0xFFFFFFFFFFFFFFD6, out_valid 33 cycles after accept (default build).
REQ-029 SHALL test: signed a = b = 0x80000000 -> product 0x4000000000000000; unsigned a = b = 0xFFFFFFFF -> 0xFFFFFFFE00000001.
REQ-030 SHALL test: out_ready held low 5 cycles in DONE, in_valid pulsed with new operands -> product stable, in_ready 0, new operands ignored; out_ready high -> IDLE next edge.
REQ-031 SHALL test: rst low at BUSY cycle 10 -> out_valid 0, product 0, in_ready 1 immediately; next operation -5 * -5 -> 25.
REQ-032 SHALL test, with SEQ_MULT_EARLY_TERM_EN: b = 1 -> out_valid 2 cycles after accept; b = 0 -> product 0 after 2 cycles; b = 0x80000000 unsigned -> 33 cycles.
